serial_adder: RTL and testbench

Parametrised bit-serial adder: one full-adder cell plus a carry flip-flop, iterated over WIDTH cycles under a start/done handshake, replacing a wide combinational adder where area matters more than latency. It sits beside the combinational adder blocks in the arithmetic library. It is the sequential, width-generic successor of the single-bit full adder; at WIDTH=1 it reproduces the full-adder truth table with a one-operation latency.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_adder_fa_cell.sv | 19 +
 rtl/serial_adder.sv | 151 +++++++++++++++
 tb/tb_serial_adder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     state_e          FSM state encoding (IDLE, RUN, DONE)
//     DEFAULT_WIDTH    default operand width
//     cnt_width()      bit counter width, never less than one bit
//   Optional feature macro used by the top: SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // The counter has to reach WIDTH-1, so $clog2(WIDTH) bits suffice;
    // WIDTH=1 would give zero bits, so clamp to one.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell
//   Single-bit full adder: the per-bit datapath of the serial adder.
//   Ports:
//     a, b  in   operand bits
//     c     in   carry in
//     s     out  sum bit
//     co    out  carry out (majority of a, b, c)
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: one full-adder cell plus a carry flop iterated over
//   WIDTH cycles under a start/done handshake.
//   Handshake: start is taken only in IDLE or DONE (the "accepting edge");
//   operands, cin (and sub) are sampled on that edge. busy is high for the
//   WIDTH RUN cycles, done pulses for one cycle when sum/cout update. A start
//   seen during RUN is dropped, not queued.
//   Parameters:
//     WIDTH      operand/result width, 1..64
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     start      in   operation request
//     a, b       in   operands [WIDTH-1:0]
//     cin        in   carry in
//     sub        in   subtract select (only with SERIAL_ADDER_SUB_EN)
//     busy       out  high while in RUN
//     done       out  one-cycle completion pulse
//     sum        out  registered result [WIDTH-1:0], held until next completion
//     cout       out  registered final carry, held with sum
//     dbg_state  out  current FSM state, for observation only
//   Macro: SERIAL_ADDER_SUB_EN adds the sub port; sub=1 computes a - b and
//   cout=1 then means "no borrow".
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_e           dbg_state
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             c_q,      c_d;
    logic             cout_q,   cout_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic fa_s;
    logic fa_co;
    logic accept;
    logic sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    fa_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .c  (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        c_d      = c_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) accept = 1'b1;
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // New sum bit enters at the MSB so that after WIDTH shifts
                // bit 0 of the result sits at bit 0.
                res_sh_d = res_sh_q >> 1;
                res_sh_d[WIDTH-1] = fa_s;
                c_d      = fa_co;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    sum_d   = res_sh_d;
                    cout_d  = fa_co;
                end
            end
            S_DONE: begin
                if (start) accept  = 1'b1;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_RUN;
            a_sh_d  = a;
            // Subtraction is a + ~b + 1: invert b on load, force carry to 1.
            b_sh_d  = sub_sel ? ~b : b;
            c_d     = sub_sel ? 1'b1 : cin;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed bench for serial_adder: an 8-bit instance driven from a vector
//   table plus hand-written multi-cycle sequences, and a 1-bit instance
//   walked through the full-adder truth table.
module tb_serial_adder;
    import serial_adder_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance
    logic       start8, cin8, sub8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    state_e     dbg8;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub8),
`endif
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .cout      (cout8),
        .dbg_state (dbg8)
    );

    // 1-bit instance
    logic       start1, cin1, sub1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    state_e     dbg1;

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub1),
`endif
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .cout      (cout1),
        .dbg_state (dbg1)
    );

    // scoreboard counters
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // done pulse monitors, sampled on the rising edge (value held in the cycle before it)
    int   done_cnt8 = 0;
    int   dbl_done  = 0;
    logic prev_done8 = 1'b0;
    logic prev_done1 = 1'b0;
    always @(posedge clk) begin
        if (done8) done_cnt8 <= done_cnt8 + 1;
        if ((done8 && prev_done8) || (done1 && prev_done1)) dbl_done <= dbl_done + 1;
        prev_done8 <= done8;
        prev_done1 <= done1;
    end

    // expected previous result, for the hold check during RUN
    logic [7:0] prev_sum8  = 8'h00;
    logic       prev_cout8 = 1'b0;
    int         done_at    = 0;

    // Drives one operation on the 8-bit instance; must be called at a negedge.
    // lat = rising edges after the accepting edge until done is seen high.
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                          input logic tsub, input bit poke,
                          output logic [7:0] rs, output logic rc,
                          output int lat, output int busy_n, output int hold_err);
        a8 = ta; b8 = tb_v; cin8 = tci; sub8 = tsub; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 0; busy_n = 0; hold_err = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_n++;
            if (sum8 !== prev_sum8 || cout8 !== prev_cout8) hold_err++;
            if (poke && lat == 2) begin
                start8 = 1'b1; a8 = 8'h11; b8 = 8'h11; cin8 = 1'b1;
            end
            if (poke && lat == 3) start8 = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rs = sum8; rc = cout8; done_at = cyc;
    endtask

    task automatic do_op1(input logic ta, input logic tb_v, input logic tci,
                          output logic rs, output logic rc, output int lat);
        a1 = ta; b1 = tb_v; cin1 = tci; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rs = sum1; rc = cout1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec8_t;

    vec8_t vecs[8];

    initial begin
        logic [7:0] rs;
        logic       rc;
        logic       rs1, rc1;
        int         lat, busy_n, hold_err, first_done, base;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h35, 8'h4A, 1'b1, 8'h80, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_busy",  busy8, 0);
        check("rst_done",  done8, 0);
        check("rst_sum",   sum8,  0);
        check("rst_cout",  cout8, 0);
        check("rst_state", dbg8,  S_IDLE);
        check("rst_state1", dbg1, S_IDLE);
        rst = 1'b0;
        @(negedge clk);
        check("idle_state", dbg8, S_IDLE);

        // table: each op starts in the done cycle of the previous one
        for (int i = 0; i < 8; i++) begin
            do_op8(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 1'b0, rs, rc, lat, busy_n, hold_err);
            check($sformatf("v%0d_sum", i),  rs,  vecs[i].exp_sum);
            check($sformatf("v%0d_cout", i), rc,  vecs[i].exp_cout);
            check($sformatf("v%0d_lat", i),  lat, 8);
            check($sformatf("v%0d_busy", i), busy_n, 8);
            check($sformatf("v%0d_hold", i), hold_err, 0);
            check($sformatf("v%0d_busy_at_done", i), busy8, 0);
            prev_sum8  = vecs[i].exp_sum;
            prev_cout8 = vecs[i].exp_cout;
        end

        // back-to-back: start held in the done cycle
        first_done = done_at;
        do_op8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, rs, rc, lat, busy_n, hold_err);
        check("b2b_sum",  rs, 8'h10);
        check("b2b_cout", rc, 1'b0);
        check("b2b_gap",  done_at - first_done, 9);
        prev_sum8 = 8'h10; prev_cout8 = 1'b0;

        // start pulsed during RUN is ignored
        repeat (2) @(negedge clk);
        base = done_cnt8;
        do_op8(8'h22, 8'h33, 1'b0, 1'b0, 1'b1, rs, rc, lat, busy_n, hold_err);
        check("poke_sum",  rs, 8'h55);
        check("poke_cout", rc, 1'b0);
        check("poke_lat",  lat, 8);
        repeat (12) @(negedge clk);
        check("poke_done_pulses", done_cnt8 - base, 1);
        check("poke_idle", dbg8, S_IDLE);
        prev_sum8 = 8'h55; prev_cout8 = 1'b0;

        // reset mid-operation, after E3
        a8 = 8'h55; b8 = 8'h0A; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        base = done_cnt8;
        @(negedge clk);
        check("abort_busy",  busy8, 0);
        check("abort_done",  done8, 0);
        check("abort_sum",   sum8,  0);
        check("abort_cout",  cout8, 0);
        check("abort_state", dbg8,  S_IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_cnt8 - base, 0);
        prev_sum8 = 8'h00; prev_cout8 = 1'b0;
        do_op8(8'h21, 8'h43, 1'b0, 1'b0, 1'b0, rs, rc, lat, busy_n, hold_err);
        check("post_rst_sum",  rs, 8'h64);
        check("post_rst_lat",  lat, 8);
        check("post_rst_hold", hold_err, 0);
        prev_sum8 = 8'h64; prev_cout8 = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
        do_op8(8'h10, 8'h20, 1'b0, 1'b1, 1'b0, rs, rc, lat, busy_n, hold_err);
        check("sub_lt_sum",  rs, 8'hF0);
        check("sub_lt_cout", rc, 1'b0);
        prev_sum8 = 8'hF0; prev_cout8 = 1'b0;
        do_op8(8'h20, 8'h10, 1'b1, 1'b1, 1'b0, rs, rc, lat, busy_n, hold_err);
        check("sub_ge_sum",  rs, 8'h10);
        check("sub_ge_cout", rc, 1'b1);
        prev_sum8 = 8'h10; prev_cout8 = 1'b1;
        do_op8(8'h20, 8'h10, 1'b1, 1'b0, 1'b0, rs, rc, lat, busy_n, hold_err);
        check("sub0_sum",  rs, 8'h31);
        check("sub0_cout", rc, 1'b0);
        prev_sum8 = 8'h31; prev_cout8 = 1'b0;
`endif

        // WIDTH=1: full-adder truth table, one RUN cycle each
        for (int k = 0; k < 8; k++) begin
            logic [2:0] abc;
            logic [1:0] tot;
            abc = 3'(k);
            tot = 2'(abc[2]) + 2'(abc[1]) + 2'(abc[0]);
            do_op1(abc[2], abc[1], abc[0], rs1, rc1, lat);
            check($sformatf("fa%0d_s", k),   rs1, tot[0]);
            check($sformatf("fa%0d_co", k),  rc1, tot[1]);
            check($sformatf("fa%0d_lat", k), lat, 1);
        end
        @(negedge clk);

        check("no_double_done", dbl_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
